instr_mem_responder: RTL and testbench



---
 rtl/instr_bus_pkg.sv | 21 ++
 rtl/instr_mem_stall_lfsr.sv | 27 ++
 rtl/instr_mem_responder.sv | 112 +++++++++++
 tb/tb_instr_mem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_bus_pkg.sv
// Shared definitions for the instruction-bus responder and future memory models.
// Holds the response record, bus constants and the address-range helper.
package instr_bus_pkg;

   localparam int          INSTR_WORD_BYTES = 4;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam int          MAX_READ_LATENCY = 4;
   localparam int          MAX_OUTSTD_LIMIT = 4;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] data;
   } instr_rsp_t;

   // Word-granular compare avoids overflowing 4*words for very large memories.
   function automatic logic offset_in_range(input logic [31:0] offset, input int unsigned words);
      return {2'b00, offset[31:2]} < words;
   endfunction

endpackage

// File: rtl/instr_mem_stall_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) producing a pseudo-random
// stall request that suppresses roughly one grant in four when enabled.
module instr_mem_stall_lfsr #(
   parameter bit          STALL_EN  = 1'b0,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic clk,
   input  logic rstn,
   output logic stall_now
);

   logic [15:0] lfsr_q;
   logic        feedback;

   assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= {lfsr_q[14:0], feedback};
      end
   end

   assign stall_now = STALL_EN & (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/instr_mem_responder.sv
// Memory-side responder for the fetch instruction bus: req/gnt address phase,
// in-order rvalid/rdata/err response after a fixed latency, plus a program-load port.
module instr_mem_responder
   import instr_bus_pkg::*;
#(
   parameter int unsigned MEM_WORDS       = 4096,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          READ_LATENCY    = 1,
   parameter int          MAX_OUTSTANDING = 2,
   parameter bit          STALL_EN        = 1'b0,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_rdata_o,
   output logic        instr_rvalid_o,
   output logic        instr_err_o,
   input  logic        load_en_i,
   input  logic [31:0] load_addr_i,
   input  logic [31:0] load_data_i,
   output logic [2:0]  outstanding_o
);

   localparam int IDX_W  = $clog2(MEM_WORDS);
   localparam int BYTE_W = $clog2(INSTR_WORD_BYTES);

   if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY ||
       MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > MAX_OUTSTD_LIMIT ||
       LFSR_SEED == 16'h0000 || MEM_WORDS < 2 ||
       (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_illegal_params
      $error("instr_mem_responder: illegal parameter combination");
   end

   logic [31:0]      ram [MEM_WORDS];
   instr_rsp_t       rsp_p [READ_LATENCY];
   logic [2:0]       outstanding_q;
   logic             stall_now;
   logic [31:0]      rd_off;
   logic [31:0]      ld_off;
   logic             rd_in_range;
   logic             ld_we;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] ld_idx;
   logic             unused_byte_lanes;

   instr_mem_stall_lfsr #(
      .STALL_EN  (STALL_EN),
      .LFSR_SEED (LFSR_SEED)
   ) u_stall_lfsr (
      .clk       (clk),
      .rstn      (rstn),
      .stall_now (stall_now)
   );

   // Unsigned offsets: addresses below BASE_ADDR wrap high and decode as errors.
   assign rd_off      = instr_addr_i - BASE_ADDR;
   assign ld_off      = load_addr_i - BASE_ADDR;
   assign rd_in_range = offset_in_range(rd_off, MEM_WORDS);
   assign ld_we       = load_en_i & offset_in_range(ld_off, MEM_WORDS);
   assign rd_idx      = rd_off[IDX_W+BYTE_W-1:BYTE_W];
   assign ld_idx      = ld_off[IDX_W+BYTE_W-1:BYTE_W];
   assign unused_byte_lanes = ^{rd_off[BYTE_W-1:0], ld_off[BYTE_W-1:0]};

   assign instr_gnt_o = instr_req_i & (outstanding_q < 3'(MAX_OUTSTANDING)) & ~stall_now;

   always_ff @(posedge clk) begin
      if (ld_we) begin
         ram[ld_idx] <= load_data_i;
      end
   end

   // Stage 0 samples the RAM at grant time; a same-edge load is seen by the next read only.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            rsp_p[i] <= '0;
         end
      end else begin
         rsp_p[0] <= '{valid: instr_gnt_o,
                       err:   instr_gnt_o & ~rd_in_range,
                       data:  (instr_gnt_o & rd_in_range) ? ram[rd_idx] : 32'h0};
         for (int i = 1; i < READ_LATENCY; i++) begin
            rsp_p[i] <= rsp_p[i-1];
         end
      end
   end

   assign instr_rvalid_o = rsp_p[READ_LATENCY-1].valid;
   assign instr_err_o    = rsp_p[READ_LATENCY-1].err;
   assign instr_rdata_o  = rsp_p[READ_LATENCY-1].data;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outstanding_q <= 3'd0;
      end else begin
         case ({instr_gnt_o, instr_rvalid_o})
            2'b10:   outstanding_q <= outstanding_q + 3'd1;
            2'b01:   outstanding_q <= outstanding_q - 3'd1;
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   assign outstanding_o = outstanding_q;

   a_outstanding_bounds: assert property (@(posedge clk) disable iff (!rstn)
      (outstanding_q <= 3'(MAX_OUTSTANDING)) && !(instr_rvalid_o && outstanding_q == 3'd0));

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench: four responder configurations share one stimulus stream and one
// reference memory; grants push expected responses, a monitor pops them on rvalid.
module tb_instr_mem_responder;

   localparam int          NDUT  = 4;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int unsigned WORDS = 4096;

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req = 1'b0;
   logic [31:0] addr = 32'h0;
   logic        load_en = 1'b0;
   logic [31:0] load_addr = 32'h0;
   logic [31:0] load_data = 32'h0;

   wire         gnt    [NDUT];
   wire         rvalid [NDUT];
   wire         err    [NDUT];
   wire  [31:0] rdata  [NDUT];
   wire  [2:0]  outst  [NDUT];

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t exp_q [NDUT][$];
   int   popped_cyc [NDUT];
   logic [31:0] mem_m [int unsigned];
   bit   stall_win = 1'b0;
   bit   b2b_win = 1'b0;
   int   stall_gnts = 0;
   int   peak_b = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int k);
      case (k)
         1:       return 3;
         2:       return 4;
         default: return 1;
      endcase
   endfunction

   function automatic int max_of(input int k);
      return (k == 2) ? 4 : 2;
   endfunction

   instr_mem_responder #(.READ_LATENCY(1), .MAX_OUTSTANDING(2)) dut_a (
      .clk(clk), .rstn(rstn), .instr_req_i(req), .instr_gnt_o(gnt[0]), .instr_addr_i(addr),
      .instr_rdata_o(rdata[0]), .instr_rvalid_o(rvalid[0]), .instr_err_o(err[0]),
      .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data), .outstanding_o(outst[0]));

   instr_mem_responder #(.READ_LATENCY(3), .MAX_OUTSTANDING(2)) dut_b (
      .clk(clk), .rstn(rstn), .instr_req_i(req), .instr_gnt_o(gnt[1]), .instr_addr_i(addr),
      .instr_rdata_o(rdata[1]), .instr_rvalid_o(rvalid[1]), .instr_err_o(err[1]),
      .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data), .outstanding_o(outst[1]));

   instr_mem_responder #(.READ_LATENCY(4), .MAX_OUTSTANDING(4)) dut_c (
      .clk(clk), .rstn(rstn), .instr_req_i(req), .instr_gnt_o(gnt[2]), .instr_addr_i(addr),
      .instr_rdata_o(rdata[2]), .instr_rvalid_o(rvalid[2]), .instr_err_o(err[2]),
      .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data), .outstanding_o(outst[2]));

   instr_mem_responder #(.READ_LATENCY(1), .MAX_OUTSTANDING(2), .STALL_EN(1'b1)) dut_d (
      .clk(clk), .rstn(rstn), .instr_req_i(req), .instr_gnt_o(gnt[3]), .instr_addr_i(addr),
      .instr_rdata_o(rdata[3]), .instr_rvalid_o(rvalid[3]), .instr_err_o(err[3]),
      .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data), .outstanding_o(outst[3]));

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut=%0d cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
      end
   endtask

   // Grant tracker: checks grant/outstanding against the model and queues expectations.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) begin
            int          exp_out;
            logic        allowed;
            logic [31:0] off;
            exp_t        e;
            if (!rstn) begin
               exp_q[k].delete();
               chk("rst_gnt", k, 32'(gnt[k]), 32'h0);
               chk("rst_rvalid", k, 32'(rvalid[k]), 32'h0);
               chk("rst_err", k, 32'(err[k]), 32'h0);
               chk("rst_rdata", k, rdata[k], 32'h0);
               chk("rst_outstanding", k, 32'(outst[k]), 32'h0);
            end else begin
               exp_out = exp_q[k].size() + ((popped_cyc[k] == cyc) ? 1 : 0);
               chk("outstanding", k, 32'(outst[k]), 32'(exp_out));
               allowed = req && (exp_out < max_of(k));
               if (k == 3) chk("gnt_bound", k, 32'(gnt[k] & ~allowed), 32'h0);
               else        chk("gnt", k, 32'(gnt[k]), 32'(allowed));
               if (gnt[k]) begin
                  off    = addr - BASE;
                  e.due  = cyc + lat_of(k);
                  e.err  = (off >= 4 * WORDS);
                  e.data = e.err ? 32'h0 : mem_m[off >> 2];
                  exp_q[k].push_back(e);
                  if (k == 3 && stall_win) stall_gnts++;
               end
               if (k == 1 && b2b_win && int'(outst[1]) > peak_b) peak_b = int'(outst[1]);
            end
         end
         if (load_en && (load_addr - BASE) < 4 * WORDS) mem_m[(load_addr - BASE) >> 2] = load_data;
      end
   end

   // Response monitor: every rvalid must match the oldest expectation, on its due cycle.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (rstn) begin
            for (int k = 0; k < NDUT; k++) begin
               exp_t e;
               if (rvalid[k]) begin
                  if (exp_q[k].size() == 0) begin
                     chk("rvalid_spurious", k, 32'(rvalid[k]), 32'h0);
                  end else begin
                     e = exp_q[k].pop_front();
                     popped_cyc[k] = cyc;
                     chk("rsp_latency", k, 32'(cyc), 32'(e.due));
                     chk("rsp_err", k, 32'(err[k]), 32'(e.err));
                     chk("rsp_data", k, rdata[k], e.data);
                  end
               end else begin
                  chk("idle_rsp_zero", k, rdata[k] | 32'(err[k]), 32'h0);
                  if (exp_q[k].size() > 0 && exp_q[k][0].due <= cyc) begin
                     e = exp_q[k].pop_front();
                     popped_cyc[k] = cyc;
                     chk("rvalid_missing", k, 32'(rvalid[k]), 32'h1);
                  end
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [31:0] a, input logic le,
                        input logic [31:0] la, input logic [31:0] ld);
      req = r; addr = a; load_en = le; load_addr = la; load_data = ld;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      for (int k = 0; k < NDUT; k++) popped_cyc[k] = -1;
      repeat (3) step();
      rstn = 1'b1;

      for (int w = 0; w < 64; w++) drive(1'b0, 32'h0, 1'b1, 32'(w * 4), $urandom());
      drive(1'b0, 32'h0, 1'b1, 32'h10, 32'hDEADBEEF);
      drive(1'b0, 32'h0, 1'b1, 32'h20, 32'h11111111);
      drive(1'b0, 32'h0, 1'b1, 32'h4000, 32'hBAD0BAD0);
      idle(1);

      drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0); idle(5);
      drive(1'b1, 32'h12, 1'b0, 32'h0, 32'h0); idle(5);
      drive(1'b1, 32'h00, 1'b0, 32'h0, 32'h0); idle(6);

      b2b_win = 1'b1;
      for (int i = 0; i < 4; i++) drive(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0);
      idle(6);
      b2b_win = 1'b0;
      chk("b2b_peak_outstanding", 1, 32'(peak_b), 32'h2);

      drive(1'b1, 32'h4000, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
      idle(6);

      drive(1'b1, 32'h20, 1'b1, 32'h20, 32'h22222222);
      drive(1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
      idle(6);

      drive(1'b1, 32'h30, 1'b0, 32'h0, 32'h0);
      idle(1);
      rstn = 1'b0;
      idle(3);
      rstn = 1'b1;
      idle(8);

      for (int i = 0; i < 400; i++) begin
         logic        r, le;
         logic [31:0] a, la;
         r  = ($urandom_range(0, 3) != 0);
         a  = ($urandom_range(0, 15) == 0) ? (32'h4000 + 32'($urandom_range(0, 255) << 2))
                                           : 32'($urandom_range(0, 255));
         le = ($urandom_range(0, 3) == 0);
         la = ($urandom_range(0, 15) == 0) ? 32'h8000 : 32'($urandom_range(0, 63) << 2);
         drive(r, a, le, la, $urandom());
      end
      idle(8);

      stall_win = 1'b1;
      for (int i = 0; i < 1000; i++) drive(1'b1, 32'($urandom_range(0, 63) << 2), 1'b0, 32'h0, 32'h0);
      stall_win = 1'b0;
      idle(10);

      total++;
      if (stall_gnts < 700 || stall_gnts > 800) begin
         bad++;
         $display("FAIL stall_duty got=%0d grants per 1000 cycles want 700..800", stall_gnts);
      end
      for (int k = 0; k < NDUT; k++) chk("drain_empty", k, 32'(exp_q[k].size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
